exu_mdu: RTL and testbench

Iterative multiply/divide execute unit implementing the RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the combinational ALU in the execute stage. It is generalised in operand width and in iterations per cycle, and it uses valid/ready handshakes on both its input and output. The pipeline stalls while the unit is busy and can flush it on redirect.

---
 rtl/exu_mdu.sv | 162 ++++++++++++++++
 tb/tb_exu_mdu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mdu.sv
// Iterative RV M-extension multiply/divide unit. Shift-add multiply and
// restoring divide on operand magnitudes, ITER_PER_CYCLE steps per clock,
// with sign correction and result selection applied on the final step.
module exu_mdu #(
    parameter int XLEN           = 32,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [7:0]      mdu_fun_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int                CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN / ITER_PER_CYCLE);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic              neg_q;
    logic              op_mul_q, op_hi_q, op_rem_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div, sgn1, sgn2, s1, s2, neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN:0]     sum, rem_sh;
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_rem, fin_res;

    assign accept      = in_valid_i && (state_q == IDLE) && !flush_i;
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

    // Operand decode: magnitudes, result sign and fast-path detection.
    always_comb begin
        is_div   = |mdu_fun_i[7:4];
        sgn1     = mdu_fun_i[0] | mdu_fun_i[1] | mdu_fun_i[2] | mdu_fun_i[4] | mdu_fun_i[6];
        sgn2     = mdu_fun_i[0] | mdu_fun_i[1] | mdu_fun_i[4] | mdu_fun_i[6];
        s1       = sgn1 & rs1_i[XLEN-1];
        s2       = sgn2 & rs2_i[XLEN-1];
        mag1     = s1 ? -rs1_i : rs1_i;
        mag2     = s2 ? -rs2_i : rs2_i;
        // MULHSU and REM take the sign of rs1 only.
        neg      = (mdu_fun_i[2] | mdu_fun_i[6]) ? s1 : (s1 ^ s2);
        div_zero = is_div && (rs2_i == '0);
        div_ovf  = (mdu_fun_i[4] | mdu_fun_i[6]) && (rs1_i == MIN_NEG) && (rs2_i == '1);
        fast     = (mdu_fun_i == '0) || div_zero || div_ovf;
        fast_res = '0;
        if (div_zero) begin
            fast_res = (mdu_fun_i[4] | mdu_fun_i[5]) ? '1 : rs1_i;
        end else if (div_ovf) begin
            fast_res = mdu_fun_i[4] ? rs1_i : '0;
        end
    end

    // ITER_PER_CYCLE shift-add or restoring-divide steps on the accumulator.
    always_comb begin
        step_acc = acc_q;
        sum      = '0;
        rem_sh   = '0;
        addend   = '0;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (op_mul_q) begin
                addend   = step_acc[0] ? opb_q : '0;
                sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + {1'b0, addend};
                step_acc = {sum, step_acc[XLEN-1:1]};
            end else begin
                rem_sh = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                if (rem_sh >= {1'b0, opb_q}) begin
                    rem_sh   = rem_sh - {1'b0, opb_q};
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Final sign correction and result selection for the last step.
    always_comb begin
        prod    = neg_q ? -step_acc : step_acc;
        quo_rem = op_rem_q ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        if (op_mul_q) begin
            fin_res = op_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end else begin
            fin_res = neg_q ? -quo_rem : quo_rem;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (cnt_q == CNT_ONE) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // State, operand latching, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            op_mul_q <= 1'b0;
            op_hi_q  <= 1'b0;
            op_rem_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q    <= CNT_INIT;
                neg_q    <= neg;
                op_mul_q <= |mdu_fun_i[3:0];
                op_hi_q  <= |mdu_fun_i[3:1];
                op_rem_q <= mdu_fun_i[6] | mdu_fun_i[7];
                if (|mdu_fun_i[3:0]) begin
                    acc_q <= {{XLEN{1'b0}}, mag2};
                    opb_q <= mag1;
                end else begin
                    acc_q <= {{XLEN{1'b0}}, mag1};
                    opb_q <= mag2;
                end
                if (fast) result_q <= fast_res;
            end else if (state_q == CALC) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) result_q <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Bench for exu_mdu: two instances (1 and 2 steps per cycle) share the inputs
// and are checked against a 64-bit arithmetic reference model.
module tb_exu_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, flush, out_ready;
    logic [XLEN-1:0] rs1, rs2;
    logic [7:0]      fun;
    logic            rdy1, ov1, busy1, rdy2, ov2, busy2;
    logic [XLEN-1:0] res1, res2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_mdu #(.XLEN(XLEN), .ITER_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .rs1_i(rs1), .rs2_i(rs2), .mdu_fun_i(fun), .flush_i(flush),
        .out_valid_o(ov1), .out_ready_i(out_ready), .result_o(res1), .busy_o(busy1)
    );

    exu_mdu #(.XLEN(XLEN), .ITER_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .rs1_i(rs1), .rs2_i(rs2), .mdu_fun_i(fun), .flush_i(flush),
        .out_valid_o(ov2), .out_ready_i(out_ready), .result_o(res2), .busy_o(busy2)
    );

    function automatic logic [31:0] model(input logic [7:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            8'h01: return a * b;
            8'h02: begin p = sa * sb; return p[63:32]; end
            8'h04: begin p = sa * $signed(ub); return p[63:32]; end
            8'h08: begin up = ua * ub; return up[63:32]; end
            8'h10: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            8'h20: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            8'h40: return (b == 0) ? a : 32'(sa % sb);
            8'h80: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_fast(input logic [7:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        return (f == 8'h00) || ((f[4] | f[5] | f[6] | f[7]) && b == 0) ||
               ((f[4] | f[6]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready high; check result, latency and in_ready on both units.
    task automatic run_op(input string name, input logic [7:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_l1, exp_l2, lat1, lat2, cyc;
        logic [31:0] r1, r2;
        logic        bad1, bad2, after1, after2;
        bit          done;
        exp_res = model(f, a, b);
        exp_l1  = is_fast(f, a, b) ? 1 : XLEN + 1;
        exp_l2  = is_fast(f, a, b) ? 1 : XLEN / 2 + 1;
        lat1 = 0; lat2 = 0; r1 = '0; r2 = '0;
        bad1 = 1'b0; bad2 = 1'b0; after1 = 1'b0; after2 = 1'b0;
        done = 1'b0; cyc = 1;
        out_ready = 1'b1;
        fun = f; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!done && cyc <= 100) begin
            if (lat1 == 0) begin
                if (rdy1 !== 1'b0) bad1 = 1'b1;
                if (ov1 === 1'b1) begin lat1 = cyc; r1 = res1; end
            end else if (cyc == lat1 + 1) begin
                after1 = rdy1;
            end
            if (lat2 == 0) begin
                if (rdy2 !== 1'b0) bad2 = 1'b1;
                if (ov2 === 1'b1) begin lat2 = cyc; r2 = res2; end
            end else if (cyc == lat2 + 1) begin
                after2 = rdy2;
            end
            if (lat1 != 0 && lat2 != 0 && cyc > lat1 && cyc > lat2) done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " result1"}, r1, exp_res);
        chk({name, " result2"}, r2, exp_res);
        chk({name, " latency1"}, 32'(lat1), 32'(exp_l1));
        chk({name, " latency2"}, 32'(lat2), 32'(exp_l2));
        chk({name, " ready_low1"}, {31'd0, bad1}, 32'd0);
        chk({name, " ready_low2"}, {31'd0, bad2}, 32'd0);
        chk({name, " ready_after1"}, {31'd0, after1}, 32'd1);
        chk({name, " ready_after2"}, {31'd0, after2}, 32'd1);
    endtask

    // Start a long op, abort it in cycle 10 with flush or reset.
    task automatic abort_op(input bit use_rst);
        logic bad;
        bad = 1'b0;
        fun = 8'h01; rs1 = 32'd12345; rs2 = 32'd678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (ov1 !== 1'b0 || ov2 !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk(use_rst ? "rst no_valid" : "flush no_valid", {31'd0, bad}, 32'd0);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        chk("abort valid1", {31'd0, ov1}, 32'd0);
        chk("abort valid2", {31'd0, ov2}, 32'd0);
        chk("abort ready1", {31'd0, rdy1}, 32'd1);
        chk("abort ready2", {31'd0, rdy2}, 32'd1);
        chk("abort busy1", {31'd0, busy1}, 32'd0);
        if (use_rst) begin
            chk("rst result1", res1, 32'd0);
            chk("rst result2", res2, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held, exp_bp, a, b;
        logic [7:0]  f;
        logic        bad;
        int          idx, k, wait_cnt;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; fun = '0;
        @(posedge clk); #1;
        chk("reset result", res1, 32'd0);
        chk("reset valid", {31'd0, ov1}, 32'd0);
        chk("reset busy", {31'd0, busy1}, 32'd0);
        chk("reset ready", {31'd0, rdy1}, 32'd1);
        chk("reset result2", res2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul", 8'h01, 32'd7, 32'hFFFF_FFFD);
        chk("mul const", res1, 32'hFFFF_FFEB);
        run_op("mulh", 8'h02, 32'h8000_0000, 32'h8000_0000);
        chk("mulh const", res1, 32'h4000_0000);
        run_op("mulhu", 8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu const", res1, 32'hFFFF_FFFE);
        run_op("mulhsu", 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhsu const", res1, 32'hFFFF_FFFF);
        run_op("div", 8'h10, 32'hFFFF_FFF9, 32'd2);
        chk("div const", res1, 32'hFFFF_FFFD);
        run_op("rem", 8'h40, 32'hFFFF_FFF9, 32'd2);
        chk("rem const", res1, 32'hFFFF_FFFF);
        run_op("divu", 8'h20, 32'd100, 32'd7);
        chk("divu const", res1, 32'd14);
        run_op("remu", 8'h80, 32'd100, 32'd7);
        chk("remu const", res1, 32'd2);
        run_op("div0", 8'h10, 32'd5, 32'd0);
        chk("div0 const", res1, 32'hFFFF_FFFF);
        run_op("remu0", 8'h80, 32'd5, 32'd0);
        chk("remu0 const", res1, 32'd5);
        run_op("divovf", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf const", res1, 32'h8000_0000);
        run_op("removf", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("removf const", res1, 32'd0);
        run_op("nop", 8'h00, 32'd55, 32'd66);

        // Backpressure: hold DONE for five cycles.
        out_ready = 1'b0;
        exp_bp = model(8'h02, 32'hDEAD_BEEF, 32'h1234_5678);
        fun = 8'h02; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (ov1 !== 1'b1 && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("bp reached done", {31'd0, ov1}, 32'd1);
        held = res1;
        chk("bp result", held, exp_bp);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ov1 !== 1'b1 || res1 !== held || rdy1 !== 1'b0) bad = 1'b1;
            if (ov2 !== 1'b1 || res2 !== exp_bp || rdy2 !== 1'b0) bad = 1'b1;
        end
        chk("bp stable", {31'd0, bad}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp ready1", {31'd0, rdy1}, 32'd1);
        chk("bp ready2", {31'd0, rdy2}, 32'd1);
        chk("bp valid drop", {31'd0, ov1}, 32'd0);
        chk("bp result kept", res1, exp_bp);
        run_op("b2b", 8'h20, 32'd1000, 32'd33);

        // Abort by flush, then by reset, each followed by DIVU 9/3.
        abort_op(1'b0);
        run_op("after flush", 8'h20, 32'd9, 32'd3);
        abort_op(1'b1);
        run_op("after rst", 8'h20, 32'd9, 32'd3);

        // in_valid together with flush must not be accepted.
        fun = 8'h20; rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush+valid busy1", {31'd0, busy1}, 32'd0);
        chk("flush+valid busy2", {31'd0, busy2}, 32'd0);
        chk("flush+valid ready", {31'd0, rdy1}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("flush+valid no result", {31'd0, ov1 | ov2}, 32'd0);

        // Randomised ops with biased corner operands.
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 8);
            f = (idx == 8) ? 8'h00 : 8'(1 << idx);
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) b = $urandom_range(1, 15);
            run_op($sformatf("rand%0d op%02h", n, f), f, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
